pop_counter_bank: RTL and testbench

//  Parametrised per-channel pop counter for the transaction-layer FIFO bank.

---
 rtl/pop_counter_bank_pkg.sv | 5 +
 rtl/pop_counter_ch.sv | 32 +++
 rtl/pop_counter_bank.sv | 80 ++++++++
 tb/tb_pop_counter_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pop_counter_bank_pkg.sv
// pop_counter_bank_pkg: shared FSM state encodings for the pop counter bank
package pop_counter_bank_pkg;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_DUMP = 1'b1;
endpackage

// File: rtl/pop_counter_ch.sv
// pop_counter_ch: one channel pop counter with wrap/saturate, clear-on-read and sticky overflow
module pop_counter_ch #(
   parameter int CNT_W     = 3,
   parameter int SAT_MODE  = 0,
   parameter int CLR_ON_RD = 0
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             inc,
   input  logic             clr_rd,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);
   localparam logic [CNT_W-1:0] MAX = '1;
   logic             hit;
   logic [CNT_W-1:0] bumped, cnt_nxt;
   // next count: a pop at max either wraps or saturates; a clearing read keeps the same-cycle pop
   always_comb begin
      hit     = inc && count == MAX;
      bumped  = hit ? (SAT_MODE != 0 ? MAX : '0) : count + CNT_W'(inc);
      cnt_nxt = (CLR_ON_RD != 0 && clr_rd) ? CNT_W'(inc) : bumped;
   end
   // counter and sticky overflow; a read clears overflow unless it overflows again that cycle
   always_ff @(posedge clk or negedge reset_L)
      if (!reset_L) begin
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         count    <= cnt_nxt;
         overflow <= hit | (overflow & ~clr_rd);
      end
endmodule

// File: rtl/pop_counter_bank.sv
// pop_counter_bank: per-channel pop counters with single-read and sequential dump readout
module pop_counter_bank
   import pop_counter_bank_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 3,
   parameter int SEL_W     = 2,
   parameter int SAT_MODE  = 0,
   parameter int CLR_ON_RD = 0
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              enable,
   input  logic [NUM_CH-1:0] pop,
   input  logic              request,
   input  logic [SEL_W-1:0]  select,
   input  logic              dump,
   output logic [CNT_W-1:0]  contador,
   output logic [SEL_W-1:0]  contador_ch,
   output logic              valid,
   output logic              busy,
   output logic [NUM_CH-1:0] overflow
);
   logic [0:0]                   state;
   logic [SEL_W-1:0]             ptr, rd_ch;
   logic                         rd_fire, rd_ok, last;
   logic [NUM_CH-1:0][CNT_W-1:0] counts;
   logic [NUM_CH-1:0]            rd_sel;
   logic [CNT_W-1:0]             sample;

   assign busy = state == ST_DUMP;

   // read arbitration: an active dump owns the port, then a new dump, then a single request
   always_comb begin
      rd_fire = busy | dump | request;
      rd_ch   = busy ? ptr : dump ? '0 : select;
      rd_ok   = {1'b0, rd_ch} < (SEL_W+1)'(NUM_CH);
      sample  = rd_ok ? counts[rd_ch] : '0;
      last    = ptr == SEL_W'(NUM_CH - 1);
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign rd_sel[c] = rd_fire && rd_ch == SEL_W'(c);
      pop_counter_ch #(.CNT_W(CNT_W), .SAT_MODE(SAT_MODE), .CLR_ON_RD(CLR_ON_RD)) u_ch (
         .clk      (clk),
         .reset_L  (reset_L),
         .inc      (enable & pop[c]),
         .clr_rd   (rd_sel[c]),
         .count    (counts[c]),
         .overflow (overflow[c])
      );
   end

   // dump sequencer: channel 0 is read on entry, then one channel per cycle up to the last
   always_ff @(posedge clk or negedge reset_L)
      if (!reset_L) begin
         state <= ST_IDLE;
         ptr   <= '0;
      end else if (busy) begin
         state <= last ? ST_IDLE : ST_DUMP;
         ptr   <= last ? '0 : ptr + SEL_W'(1);
      end else if (dump) begin
         state <= ST_DUMP;
         ptr   <= SEL_W'(1);
      end

   // registered readout; contador holds its last value between reads
   always_ff @(posedge clk or negedge reset_L)
      if (!reset_L) begin
         contador    <= '0;
         contador_ch <= '0;
         valid       <= 1'b0;
      end else begin
         valid <= rd_fire;
         if (rd_fire) begin
            contador    <= sample;
            contador_ch <= rd_ch;
         end
      end
endmodule

// File: tb/tb_pop_counter_bank.sv
// tb_pop_counter_bank: scoreboard bench driving wrap, saturate and clear-on-read banks in parallel
module tb_pop_counter_bank;
   logic       clk = 1'b0, reset_L = 1'b0, enable = 1'b0, request = 1'b0, dump = 1'b0;
   logic [3:0] pop = '0;
   logic [1:0] select = '0;
   logic [2:0] contador [3];
   logic [1:0] ch_o [3];
   logic       valid_o [3], busy_o [3];
   logic [3:0] ovf_o [3];

   typedef struct packed {
      logic [1:0]      ch;
      logic [2:0][2:0] cnt;
   } exp_t;
   exp_t q[$];
   int   m_cnt [3][4];
   bit   m_ovf [3][4];
   bit   m_busy;
   int   m_ptr;
   int   errors = 0, checks = 0;

   always #5 clk = ~clk;

   pop_counter_bank #(.SAT_MODE(0), .CLR_ON_RD(0)) dut_wrap (
      .clk(clk), .reset_L(reset_L), .enable(enable), .pop(pop), .request(request),
      .select(select), .dump(dump), .contador(contador[0]), .contador_ch(ch_o[0]),
      .valid(valid_o[0]), .busy(busy_o[0]), .overflow(ovf_o[0]));
   pop_counter_bank #(.SAT_MODE(1), .CLR_ON_RD(0)) dut_sat (
      .clk(clk), .reset_L(reset_L), .enable(enable), .pop(pop), .request(request),
      .select(select), .dump(dump), .contador(contador[1]), .contador_ch(ch_o[1]),
      .valid(valid_o[1]), .busy(busy_o[1]), .overflow(ovf_o[1]));
   pop_counter_bank #(.SAT_MODE(0), .CLR_ON_RD(1)) dut_clr (
      .clk(clk), .reset_L(reset_L), .enable(enable), .pop(pop), .request(request),
      .select(select), .dump(dump), .contador(contador[2]), .contador_ch(ch_o[2]),
      .valid(valid_o[2]), .busy(busy_o[2]), .overflow(ovf_o[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 4; i++) begin
            m_cnt[k][i] = 0;
            m_ovf[k][i] = 0;
         end
      m_busy = 0;
      m_ptr  = 0;
      q.delete();
   endtask

   task automatic do_reset();
      enable  = 1'b1;
      pop     = 4'hF;
      request = 1'b0;
      dump    = 1'b0;
      reset_L = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_valid%0d", k), valid_o[k], 0);
         chk($sformatf("rst_busy%0d", k), busy_o[k], 0);
         chk($sformatf("rst_cnt%0d", k), contador[k], 0);
         chk($sformatf("rst_ch%0d", k), ch_o[k], 0);
         chk($sformatf("rst_ovf%0d", k), ovf_o[k], 0);
      end
      model_clear();
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("rst_hold_cnt%0d", k), contador[k], 0);
      reset_L = 1'b1;
      pop     = '0;
      enable  = 1'b0;
   endtask

   task automatic cycle(input logic en, input logic [3:0] p, input logic rq,
                        input logic [1:0] sel, input logic dp);
      exp_t e;
      bit   fire, inc, hit, rd;
      int   ch;
      logic [3:0] ev;
      enable = en; pop = p; request = rq; select = sel; dump = dp;
      fire = 1; ch = 0;
      if (m_busy) ch = m_ptr;
      else if (dp) ch = 0;
      else if (rq) ch = sel;
      else fire = 0;
      if (fire) begin
         e.ch = 2'(ch);
         for (int k = 0; k < 3; k++) e.cnt[k] = 3'(m_cnt[k][ch]);
         q.push_back(e);
      end
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 4; i++) begin
            inc = en & p[i];
            hit = inc && m_cnt[k][i] == 7;
            rd  = fire && ch == i;
            if (k == 2 && rd) m_cnt[k][i] = inc ? 1 : 0;
            else if (hit) m_cnt[k][i] = (k == 1) ? 7 : 0;
            else if (inc) m_cnt[k][i]++;
            m_ovf[k][i] = rd ? hit : (m_ovf[k][i] | hit);
         end
      if (m_busy) begin
         if (m_ptr == 3) begin m_busy = 0; m_ptr = 0; end
         else m_ptr++;
      end else if (dp) begin
         m_busy = 1;
         m_ptr  = 1;
      end
      @(posedge clk);
      #1;
      if (fire) e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("valid%0d", k), valid_o[k], fire);
         chk($sformatf("busy%0d", k), busy_o[k], m_busy);
         for (int i = 0; i < 4; i++) ev[i] = m_ovf[k][i];
         chk($sformatf("ovf%0d", k), ovf_o[k], ev);
         if (fire) begin
            chk($sformatf("ch%0d", k), ch_o[k], e.ch);
            chk($sformatf("cnt%0d", k), contador[k], e.cnt[k]);
         end
      end
   endtask

   initial begin
      model_clear();
      #2;
      // 1: reset with pops active, then three pops on ch2 and a single read
      do_reset();
      repeat (3) cycle(1, 4'b0100, 0, 0, 0);
      cycle(1, 4'b0000, 1, 2, 0);
      chk("t1_cnt", contador[0], 3);
      chk("t1_ch", ch_o[0], 2);
      // 2: nine pops on ch0 wrap to 1 or saturate at 7; overflow sticky until read
      do_reset();
      repeat (9) cycle(1, 4'b0001, 0, 0, 0);
      chk("t2_ovf_pre", ovf_o[0][0], 1);
      cycle(1, 4'b0000, 1, 0, 0);
      chk("t2_wrap", contador[0], 1);
      chk("t2_sat", contador[1], 7);
      chk("t2_ovf_post", ovf_o[1][0], 0);
      // 3: dump of counts 1,2,3,4 with a request dropped mid-dump
      do_reset();
      cycle(1, 4'b1111, 0, 0, 0);
      cycle(1, 4'b1110, 0, 0, 0);
      cycle(1, 4'b1100, 0, 0, 0);
      cycle(1, 4'b1000, 0, 0, 0);
      cycle(1, 4'b0000, 0, 0, 1);
      chk("t3_first", contador[0], 1);
      chk("t3_busy", busy_o[0], 1);
      cycle(1, 4'b0000, 0, 0, 0);
      cycle(1, 4'b0000, 1, 3, 0);
      cycle(1, 4'b0000, 0, 0, 0);
      chk("t3_last", contador[0], 4);
      chk("t3_last_ch", ch_o[0], 3);
      cycle(1, 4'b0000, 0, 0, 0);
      chk("t3_drop", valid_o[0], 0);
      // 4: clear-on-read keeps the pop arriving with the read
      do_reset();
      repeat (5) cycle(1, 4'b0010, 0, 0, 0);
      cycle(1, 4'b0010, 1, 1, 0);
      chk("t4_first", contador[2], 5);
      cycle(1, 4'b0000, 1, 1, 0);
      chk("t4_clr", contador[2], 1);
      chk("t4_noclr", contador[0], 6);
      // 5: disabled pops hold; dump beats a simultaneous request
      repeat (3) cycle(0, 4'b1111, 0, 0, 0);
      cycle(0, 4'b0000, 1, 2, 1);
      chk("t5_dump_ch", ch_o[0], 0);
      cycle(0, 4'b0000, 0, 0, 0);
      chk("t5_hold", contador[0], 6);
      repeat (3) cycle(0, 4'b0000, 0, 0, 0);
      // 6: reset in the middle of a dump aborts it
      cycle(1, 4'b0001, 0, 0, 1);
      cycle(1, 4'b0000, 0, 0, 0);
      do_reset();
      cycle(0, 4'b0000, 0, 0, 0);
      chk("t6_idle", valid_o[0], 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
